// File: rtl/psum_drain_ctrl.sv
// Drains psum vectors from the OFIFO into psum SRAM, optionally accumulating and applying ReLU.
// Latency: pop on POP, write on the following WB (2 cycles/vector); stalls in POP while ofifo_valid=0.
module psum_drain_ctrl #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_w  = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w-1:0]        n_vec,
    input  logic [addr_w-1:0]        base_addr,
    input  logic                     acc_en,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [psum_bw*col-1:0]   psum_in,
    output logic                     ofifo_rd,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_w-1:0]        sram_addr,
    output logic [psum_bw*col-1:0]   sram_d,
    input  logic [psum_bw*col-1:0]   sram_q,
    output logic                     busy,
    output logic                     done
);
    typedef enum logic [1:0] {IDLE, POP, WB, DONE} state_t;

    localparam logic [addr_w-1:0] one = {{(addr_w-1){1'b0}}, 1'b1};

    state_t                   state;
    state_t                   state_nxt;
    logic [addr_w-1:0]        n_reg;
    logic [addr_w-1:0]        addr_ptr;
    logic [addr_w-1:0]        cnt;
    logic [addr_w-1:0]        cnt_inc;
    logic                     acc_reg;
    logic                     relu_reg;
    logic [psum_bw*col-1:0]   hold_reg;
    logic [psum_bw*col-1:0]   d_reg;
    logic [psum_bw*col-1:0]   result;
    logic [psum_bw-1:0]       lane_sum;

    assign cnt_inc = cnt + one;

    // The stored operand is masked when not accumulating: no read was issued, so sram_q is stale.
    always_comb begin
        result   = '0;
        lane_sum = '0;
        for (int i = 0; i < col; i++) begin
            lane_sum = hold_reg[i*psum_bw +: psum_bw]
                     + (acc_reg ? sram_q[i*psum_bw +: psum_bw] : {psum_bw{1'b0}});
            result[i*psum_bw +: psum_bw] = (relu_reg && lane_sum[psum_bw-1]) ? {psum_bw{1'b0}} : lane_sum;
        end
    end

    always_comb begin
        state_nxt = state;
        ofifo_rd  = 1'b0;
        sram_cen  = 1'b1;
        sram_wen  = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = (n_vec == '0) ? DONE : POP;
            end
            POP: begin
                if (ofifo_valid) begin
                    ofifo_rd  = 1'b1;
                    sram_cen  = ~acc_reg;
                    state_nxt = WB;
                end
            end
            WB: begin
                sram_cen  = 1'b0;
                sram_wen  = 1'b0;
                state_nxt = (cnt_inc == n_reg) ? DONE : POP;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A reset cycle abandons the job immediately, including the write of the current WB.
        if (reset) begin
            ofifo_rd = 1'b0;
            sram_cen = 1'b1;
            sram_wen = 1'b1;
        end
    end

    assign sram_addr = addr_ptr;
    assign sram_d    = (state == WB && !reset) ? result : d_reg;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            n_reg    <= '0;
            addr_ptr <= '0;
            cnt      <= '0;
            acc_reg  <= 1'b0;
            relu_reg <= 1'b0;
            hold_reg <= '0;
            d_reg    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg    <= n_vec;
                        addr_ptr <= base_addr;
                        cnt      <= '0;
                        acc_reg  <= acc_en;
                        relu_reg <= relu_en;
                    end
                end
                POP: begin
                    if (ofifo_valid) hold_reg <= psum_in;
                end
                WB: begin
                    d_reg    <= result;
                    addr_ptr <= addr_ptr + one;
                    cnt      <= cnt_inc;
                end
                default: ;
            endcase
        end
    end
endmodule
